// File: rtl/axi_mst_rd_ctrl_if.sv
// ---------------------------------------------------------------------------
// axi_mst_rd_ctrl_if
// AXI read-channel bundle (AR + R) between the read controller and an AXI
// slave or interconnect.
//   master modport : drives AR payload/arvalid and rready; samples arready and
//                    the R payload.
//   slave modport  : mirror image, for a slave model or interconnect port.
// Widths come from the `AXI_*_WIDTH macros; defaults are supplied below when
// the build does not define them.
// ---------------------------------------------------------------------------
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
`define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
`define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_QOS_WIDTH
`define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
`define AXI_REGION_WIDTH 4
`endif

interface axi_mst_rd_ctrl_if;
    // AR channel
    logic                          axi_mst_arvalid;
    logic                          axi_mst_arready;
    logic [`AXI_ID_WIDTH-1:0]      axi_mst_arid;
    logic [`AXI_ADDR_WIDTH-1:0]    axi_mst_araddr;
    logic [`AXI_LEN_WIDTH-1:0]     axi_mst_arlen;
    logic [`AXI_SIZE_WIDTH-1:0]    axi_mst_arsize;
    logic [`AXI_BURST_WIDTH-1:0]   axi_mst_arburst;
    logic [`AXI_LOCK_WIDTH-1:0]    axi_mst_arlock;
    logic [`AXI_CACHE_WIDTH-1:0]   axi_mst_arcache;
    logic [`AXI_PROT_WIDTH-1:0]    axi_mst_arprot;
    logic [`AXI_QOS_WIDTH-1:0]     axi_mst_arqos;
    logic [`AXI_REGION_WIDTH-1:0]  axi_mst_arregion;
    // R channel
    logic                          axi_mst_rvalid;
    logic                          axi_mst_rready;
    logic [`AXI_ID_WIDTH-1:0]      axi_mst_rid;
    logic [`AXI_DATA_WIDTH-1:0]    axi_mst_rdata;
    logic [`AXI_RESP_WIDTH-1:0]    axi_mst_rresp;
    logic                          axi_mst_rlast;

    modport master (
        output axi_mst_arvalid, axi_mst_arid, axi_mst_araddr, axi_mst_arlen,
               axi_mst_arsize, axi_mst_arburst, axi_mst_arlock, axi_mst_arcache,
               axi_mst_arprot, axi_mst_arqos, axi_mst_arregion, axi_mst_rready,
        input  axi_mst_arready, axi_mst_rvalid, axi_mst_rid, axi_mst_rdata,
               axi_mst_rresp, axi_mst_rlast
    );

    modport slave (
        input  axi_mst_arvalid, axi_mst_arid, axi_mst_araddr, axi_mst_arlen,
               axi_mst_arsize, axi_mst_arburst, axi_mst_arlock, axi_mst_arcache,
               axi_mst_arprot, axi_mst_arqos, axi_mst_arregion, axi_mst_rready,
        output axi_mst_arready, axi_mst_rvalid, axi_mst_rid, axi_mst_rdata,
               axi_mst_rresp, axi_mst_rlast
    );
endinterface

// File: rtl/axi_mst_rd_ctrl.sv
// ---------------------------------------------------------------------------
// axi_mst_rd_ctrl
// Single-outstanding AXI read master. A user request (addr, len) is turned
// into one INCR burst on AR; returned beats are passed straight through to
// the user side with a counter-derived last flag.
//
// Parameters
//   MST_ID  : value driven on arid, and expected on rid when checking is on.
//   ARSIZE  : beat size code driven on arsize (3'b010 = 4 bytes).
// Ports
//   clk, rst_n                : clock, asynchronous active-low reset.
//   rd_req_valid/ready        : user request handshake.
//   rd_req_addr, rd_req_len   : burst start byte address, beats minus one.
//   rd_data_valid/ready       : user data handshake (zero-latency pass-through).
//   rd_data, rd_data_last     : beat data, final beat flag (from beat counter).
//   rd_data_err               : per-beat error flag.
//   axi                       : AR/R channels (axi_mst_rd_ctrl_if.master).
// Build option
//   AXI_MST_RD_RESP_CHK_EN : when defined, rd_data_err flags beats with a
//   non-OKAY rresp, an rid other than MST_ID, or an rlast that disagrees
//   with the local beat count. When undefined rd_data_err is tied low.
// ---------------------------------------------------------------------------
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
`define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
`define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_QOS_WIDTH
`define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
`define AXI_REGION_WIDTH 4
`endif

module axi_mst_rd_ctrl #(
    parameter logic [`AXI_ID_WIDTH-1:0]   MST_ID = '0,
    parameter logic [`AXI_SIZE_WIDTH-1:0] ARSIZE = 3'b010
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rd_req_valid,
    output logic                        rd_req_ready,
    input  logic [`AXI_ADDR_WIDTH-1:0]  rd_req_addr,
    input  logic [`AXI_LEN_WIDTH-1:0]   rd_req_len,
    output logic                        rd_data_valid,
    input  logic                        rd_data_ready,
    output logic [`AXI_DATA_WIDTH-1:0]  rd_data,
    output logic                        rd_data_last,
    output logic                        rd_data_err,
    axi_mst_rd_ctrl_if.master           axi
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                       state_reg, state_next;
    logic [`AXI_ADDR_WIDTH-1:0]   addr_reg;
    logic [`AXI_LEN_WIDTH-1:0]    len_reg;
    logic [`AXI_LEN_WIDTH-1:0]    beat_cnt_reg;

    logic req_hs;
    logic ar_hs;
    logic r_hs;
    logic last_beat;

    // Handshake qualifiers, each confined to the state that owns the channel
    // so stray activity elsewhere is ignored.
    assign req_hs    = (state_reg == ST_IDLE) && rd_req_valid;
    assign ar_hs     = (state_reg == ST_ADDR) && axi.axi_mst_arready;
    assign r_hs      = (state_reg == ST_DATA) && axi.axi_mst_rvalid && rd_data_ready;
    assign last_beat = (beat_cnt_reg == len_reg);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic. Slave rlast plays no part; the burst ends on the
    // locally counted final beat.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (req_hs)              state_next = ST_ADDR;
            ST_ADDR: if (ar_hs)               state_next = ST_DATA;
            ST_DATA: if (r_hs && last_beat)   state_next = ST_IDLE;
            default:                          state_next = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs. All decoded from the registered state, so arvalid cannot
    // glitch or drop before arready is seen.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_req_ready        = 1'b0;
        axi.axi_mst_arvalid = 1'b0;
        rd_data_valid       = 1'b0;
        axi.axi_mst_rready  = 1'b0;
        rd_data_last        = 1'b0;
        case (state_reg)
            ST_IDLE: rd_req_ready = 1'b1;
            ST_ADDR: axi.axi_mst_arvalid = 1'b1;
            ST_DATA: begin
                rd_data_valid      = axi.axi_mst_rvalid;
                axi.axi_mst_rready = rd_data_ready;
                rd_data_last       = last_beat;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Request latch and beat counter. The counter holds on the final beat
    // instead of incrementing, so a full-length burst never wraps it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg     <= '0;
            len_reg      <= '0;
            beat_cnt_reg <= '0;
        end else begin
            if (req_hs) begin
                addr_reg <= {rd_req_addr[`AXI_ADDR_WIDTH-1:2], 2'b00};
                len_reg  <= rd_req_len;
            end
            if (ar_hs) begin
                beat_cnt_reg <= '0;
            end else if (r_hs && !last_beat) begin
                beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
        end
    end

    // AR payload comes straight from the request registers, so it is stable
    // for the whole ADDR state.
    assign axi.axi_mst_arid     = MST_ID;
    assign axi.axi_mst_araddr   = addr_reg;
    assign axi.axi_mst_arlen    = len_reg;
    assign axi.axi_mst_arsize   = ARSIZE;
    assign axi.axi_mst_arburst  = 2'b01;
    assign axi.axi_mst_arlock   = '0;
    assign axi.axi_mst_arcache  = '0;
    assign axi.axi_mst_arprot   = '0;
    assign axi.axi_mst_arqos    = '0;
    assign axi.axi_mst_arregion = '0;

    assign rd_data = axi.axi_mst_rdata;

`ifdef AXI_MST_RD_RESP_CHK_EN
    // Flag only beats actually presented to the user in DATA.
    assign rd_data_err = (state_reg == ST_DATA) && axi.axi_mst_rvalid &&
                         ((axi.axi_mst_rresp != 2'b00) ||
                          (axi.axi_mst_rid != MST_ID) ||
                          (axi.axi_mst_rlast != last_beat));
`else
    logic unused_resp_chk;
    assign unused_resp_chk = ^{axi.axi_mst_rresp, axi.axi_mst_rid, axi.axi_mst_rlast};
    assign rd_data_err     = 1'b0;
`endif

endmodule

// File: tb/tb_axi_mst_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_mst_rd_ctrl
// Directed bench for axi_mst_rd_ctrl. The bench plays the AXI slave; each
// beat it drives pushes its expected user-side view onto a scoreboard queue,
// which is popped and compared when the user-side handshake occurs.
// Error expectations follow AXI_MST_RD_RESP_CHK_EN when it is defined.
// ---------------------------------------------------------------------------
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module tb_axi_mst_rd_ctrl;

    localparam logic [`AXI_ID_WIDTH-1:0] TB_ID = 4'h5;

    logic                        clk;
    logic                        rst_n;
    logic                        rd_req_valid;
    logic                        rd_req_ready;
    logic [`AXI_ADDR_WIDTH-1:0]  rd_req_addr;
    logic [`AXI_LEN_WIDTH-1:0]   rd_req_len;
    logic                        rd_data_valid;
    logic                        rd_data_ready;
    logic [`AXI_DATA_WIDTH-1:0]  rd_data;
    logic                        rd_data_last;
    logic                        rd_data_err;

    axi_mst_rd_ctrl_if axi_if ();

    axi_mst_rd_ctrl #(
        .MST_ID (TB_ID),
        .ARSIZE (3'b010)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_req_len    (rd_req_len),
        .rd_data_valid (rd_data_valid),
        .rd_data_ready (rd_data_ready),
        .rd_data       (rd_data),
        .rd_data_last  (rd_data_last),
        .rd_data_err   (rd_data_err),
        .axi           (axi_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [`AXI_DATA_WIDTH-1:0] data;
        logic                       last;
        logic                       err;
    } beat_t;

    beat_t sb[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected error flag for a beat as seen by the user.
    function automatic logic model_err(input logic [1:0] resp, input logic [3:0] id,
                                       input logic rl, input logic exp_last);
`ifdef AXI_MST_RD_RESP_CHK_EN
        return (resp != 2'b00) || (id != TB_ID) || (rl != exp_last);
`else
        return 1'b0 & (^{resp, id, rl, exp_last});
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one user request and check the AR payload in the first ADDR cycle.
    task automatic do_req(input logic [31:0] addr, input logic [7:0] len);
        for (int w = 0; w < 20 && !rd_req_ready; w++) tick();
        chk("req_ready_wait", rd_req_ready, 1);
        rd_req_valid = 1'b1;
        rd_req_addr  = addr;
        rd_req_len   = len;
        tick();
        rd_req_valid = 1'b0;
        rd_req_addr  = '0;
        rd_req_len   = '0;
        chk("arvalid_first", axi_if.axi_mst_arvalid, 1);
        chk("araddr", axi_if.axi_mst_araddr, {addr[31:2], 2'b00});
        chk("arlen", axi_if.axi_mst_arlen, len);
        chk("arid", axi_if.axi_mst_arid, TB_ID);
        chk("arsize", axi_if.axi_mst_arsize, 3'b010);
        chk("arburst", axi_if.axi_mst_arburst, 2'b01);
        chk("ar_const0", {axi_if.axi_mst_arlock, axi_if.axi_mst_arcache, axi_if.axi_mst_arprot,
                          axi_if.axi_mst_arqos, axi_if.axi_mst_arregion}, 0);
        chk("req_ready_addr", rd_req_ready, 0);
    endtask

    // Hold arready low for n_wait cycles, then complete the AR handshake.
    task automatic ar_handshake(input int n_wait, input logic [31:0] exp_addr);
        for (int k = 0; k < n_wait; k++) begin
            chk("arvalid_hold", axi_if.axi_mst_arvalid, 1);
            chk("araddr_hold", axi_if.axi_mst_araddr, exp_addr);
            tick();
        end
        axi_if.axi_mst_arready = 1'b1;
        #1;
        chk("arvalid_hs", axi_if.axi_mst_arvalid, 1);
        tick();
        axi_if.axi_mst_arready = 1'b0;
        chk("arvalid_drop", axi_if.axi_mst_arvalid, 0);
        chk("req_ready_data", rd_req_ready, 0);
    endtask

    // Present one R beat; the user stalls for ready_delay cycles first.
    task automatic send_beat(input logic [31:0] data, input logic [1:0] resp,
                             input logic rl, input logic exp_last, input int ready_delay);
        beat_t exp_b;
        beat_t got_b;
        axi_if.axi_mst_rvalid = 1'b1;
        axi_if.axi_mst_rdata  = data;
        axi_if.axi_mst_rresp  = resp;
        axi_if.axi_mst_rid    = TB_ID;
        axi_if.axi_mst_rlast  = rl;
        exp_b.data = data;
        exp_b.last = exp_last;
        exp_b.err  = model_err(resp, TB_ID, rl, exp_last);
        sb.push_back(exp_b);
        rd_data_ready = 1'b0;
        for (int k = 0; k < ready_delay; k++) begin
            #1;
            chk("stall_rready", axi_if.axi_mst_rready, 0);
            chk("stall_valid", rd_data_valid, 1);
            chk("stall_data", rd_data, data);
            tick();
        end
        rd_data_ready = 1'b1;
        #1;
        chk("beat_rready", axi_if.axi_mst_rready, 1);
        if (rd_data_valid && rd_data_ready) begin
            got_b = sb.pop_front();
            chk("beat_data", rd_data, got_b.data);
            chk("beat_last", rd_data_last, got_b.last);
            chk("beat_err", rd_data_err, got_b.err);
            $display("beat data=0x%08h last=%0b err=%0b", rd_data, rd_data_last, rd_data_err);
        end else begin
            chk("beat_valid", rd_data_valid, 1);
        end
        tick();
        axi_if.axi_mst_rvalid = 1'b0;
        axi_if.axi_mst_rlast  = 1'b0;
        axi_if.axi_mst_rresp  = 2'b00;
        rd_data_ready         = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                  = 1'b0;
        rd_req_valid           = 1'b0;
        rd_req_addr            = '0;
        rd_req_len             = '0;
        rd_data_ready          = 1'b0;
        axi_if.axi_mst_arready = 1'b0;
        axi_if.axi_mst_rvalid  = 1'b0;
        axi_if.axi_mst_rid     = '0;
        axi_if.axi_mst_rdata   = '0;
        axi_if.axi_mst_rresp   = '0;
        axi_if.axi_mst_rlast   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arvalid", axi_if.axi_mst_arvalid, 0);
        chk("rst_data_valid", rd_data_valid, 0);
        chk("rst_rready", axi_if.axi_mst_rready, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_req_ready", rd_req_ready, 1);
        chk("rst_araddr", axi_if.axi_mst_araddr, 0);
        chk("rst_arlen", axi_if.axi_mst_arlen, 0);

        // Stray rvalid in IDLE is ignored
        axi_if.axi_mst_rvalid = 1'b1;
        rd_data_ready         = 1'b1;
        #1;
        chk("idle_stray_valid", rd_data_valid, 0);
        chk("idle_stray_rready", axi_if.axi_mst_rready, 0);
        axi_if.axi_mst_rvalid = 1'b0;
        rd_data_ready         = 1'b0;

        // Unaligned address, len 3, arready after two arvalid cycles
        do_req(32'h0000_0103, 8'd3);
        axi_if.axi_mst_rvalid = 1'b1;
        rd_data_ready         = 1'b1;
        #1;
        chk("addr_stray_valid", rd_data_valid, 0);
        chk("addr_stray_rready", axi_if.axi_mst_rready, 0);
        axi_if.axi_mst_rvalid = 1'b0;
        rd_data_ready         = 1'b0;
        ar_handshake(1, 32'h0000_0100);
        for (int i = 0; i < 4; i++)
            send_beat(32'hA000_0000 + i, 2'b00, i == 3, i == 3, 0);
        chk("burst1_idle", rd_req_ready, 1);

        // Single beat with user stalling three cycles
        do_req(32'h0000_0200, 8'd0);
        ar_handshake(0, 32'h0000_0200);
        send_beat(32'hB000_0000, 2'b00, 1'b1, 1'b1, 3);
        chk("single_idle", rd_req_ready, 1);

        // Back-to-back bursts: second arvalid two cycles after last beat
        do_req(32'h0000_0300, 8'd1);
        ar_handshake(0, 32'h0000_0300);
        send_beat(32'hC000_0000, 2'b00, 1'b0, 1'b0, 0);
        send_beat(32'hC000_0001, 2'b00, 1'b1, 1'b1, 0);
        chk("b2b_idle_ready", rd_req_ready, 1);
        chk("b2b_idle_arvalid", axi_if.axi_mst_arvalid, 0);
        do_req(32'h0000_0404, 8'd0);
        ar_handshake(0, 32'h0000_0404);
        send_beat(32'hC100_0000, 2'b00, 1'b1, 1'b1, 0);

        // Maximum length: 256 beats, last only on the final one
        do_req(32'h0000_1000, 8'hFF);
        ar_handshake(0, 32'h0000_1000);
        for (int i = 0; i < 256; i++)
            send_beat($urandom, 2'b00, i == 255, i == 255, 0);
        chk("maxlen_idle", rd_req_ready, 1);

        // Bad rresp on beat 1, early rlast on beat 2 (FSM ignores rlast)
        do_req(32'h0000_2000, 8'd3);
        ar_handshake(0, 32'h0000_2000);
        send_beat(32'hD000_0000, 2'b10, 1'b0, 1'b0, 0);
        send_beat(32'hD000_0001, 2'b00, 1'b1, 1'b0, 0);
        chk("early_rlast_busy", rd_req_ready, 0);
        send_beat(32'hD000_0002, 2'b00, 1'b0, 1'b0, 0);
        send_beat(32'hD000_0003, 2'b00, 1'b1, 1'b1, 0);
        chk("err_burst_idle", rd_req_ready, 1);

        // Reset during beat 2 of a len-7 burst
        do_req(32'h0000_3000, 8'd7);
        ar_handshake(0, 32'h0000_3000);
        send_beat(32'hE000_0000, 2'b00, 1'b0, 1'b0, 0);
        axi_if.axi_mst_rvalid = 1'b1;
        axi_if.axi_mst_rdata  = 32'hE000_0001;
        rd_data_ready         = 1'b0;
        #1;
        chk("pre_rst_valid", rd_data_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rd_data_valid, 0);
        chk("mid_rst_rready", axi_if.axi_mst_rready, 0);
        chk("mid_rst_arvalid", axi_if.axi_mst_arvalid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", rd_req_ready, 1);
        chk("post_rst_araddr", axi_if.axi_mst_araddr, 0);
        chk("post_rst_arlen", axi_if.axi_mst_arlen, 0);
        rd_data_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("post_rst_no_beat", rd_data_valid, 0);
            tick();
        end
        axi_if.axi_mst_rvalid = 1'b0;
        rd_data_ready         = 1'b0;

        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_mst_rd_ctrl.md
AXI_MST_RD_CTRL -- requirements
Module: axi_mst_rd_ctrl

Interface
REQ-001 SHALL have parameter MST_ID, default 0, value driven on axi_mst_arid; rid checked against it.
REQ-002 SHALL have parameter ARSIZE, default 3'b010, beat size (4 bytes, matches `AXI_DATA_WIDTH of 32).
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 rd_req_valid  in  1  user read request valid.
REQ-006 rd_req_ready  out  1  block can accept a request.
REQ-007 rd_req_addr  in  `AXI_ADDR_WIDTH  burst start byte address.
REQ-008 rd_req_len  in  `AXI_LEN_WIDTH  beats minus one.
REQ-009 rd_data_valid  out  1  returned beat valid.
REQ-010 rd_data_ready  in  1  user accepts beat.
REQ-011 rd_data  out  `AXI_DATA_WIDTH  returned beat data.
REQ-012 rd_data_last  out  1  final beat of burst (counter-derived).
REQ-013 rd_data_err  out  1  beat error flag (see Configuration).
REQ-014 axi_mst_arvalid / axi_mst_arready  out / in  1 / 1  AR handshake.
REQ-015 axi_mst_arid, araddr, arlen  out  `AXI_ID/ADDR/LEN_WIDTH  AR payload.
REQ-016 axi_mst_arsize, arburst  out  `AXI_SIZE/BURST_WIDTH  ARSIZE, INCR (2'b01).
REQ-017 axi_mst_arlock, arcache, arprot, arqos, arregion  out  respective `AXI_*_WIDTH  constant 0.
REQ-018 axi_mst_rvalid / axi_mst_rready  in / out  1 / 1  R handshake.
REQ-019 axi_mst_rid, rdata, rresp, rlast  in  `AXI_ID/DATA/RESP_WIDTH, 1  R payload.

Function
REQ-020 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE; one outstanding burst max.
REQ-021 IDLE: rd_req_ready=1; rd_req_valid high latches addr (low 2 bits forced 0) and len, next state ADDR.
REQ-022 ADDR: arvalid=1, AR payload registered and stable until arready sampled high, then DATA; arvalid SHALL NOT deassert before handshake.
REQ-023 Earliest arvalid: cycle after request acceptance; rd_req_ready=0 in ADDR and DATA.
REQ-024 DATA: rd_data_valid=rvalid, rd_data=rdata, axi_mst_rready=rd_data_ready (combinational pass-through, zero latency).
REQ-025 Beat counter (`AXI_LEN_WIDTH bits) clears on AR handshake, increments per rvalid&&rready.
REQ-026 rd_data_last=1 when counter==latched len; that beat's handshake returns FSM to IDLE.
REQ-027 Slave rlast SHALL NOT alter FSM; len=0 gives single beat; len=max (all ones) gives 2^`AXI_LEN_WIDTH beats without counter overflow.
REQ-028 Outside DATA: rd_data_valid=0, axi_mst_rready=0; stray rvalid ignored.
REQ-029 New request SHALL be acceptable in the cycle IDLE is re-entered (back-to-back bursts, one idle cycle).

Reset
REQ-030 rst_n low SHALL immediately force IDLE, counter 0, arvalid 0, latched addr/len 0, rd_req_ready 1 after release; rd_data_valid/rready 0.
REQ-031 Reset mid-burst SHALL abandon burst; no beats delivered after release.

Configuration
REQ-032 Macro AXI_MST_RD_RESP_CHK_EN defined: rd_data_err=1 on a beat if rresp!=2'b00, rid!=MST_ID, or rlast!=rd_data_last; undefined: rd_data_err tied 0, no check logic.

Verification
REQ-033 addr 0x103, len 3, arready after 2 cycles -> araddr 0x100, arlen 3, arvalid held 2 cycles, 4 beats, rd_data_last on 4th only.
REQ-034 len 0, rvalid with rd_data_ready low 3 cycles -> rready low, beat held; single beat with last, FSM IDLE next cycle.
REQ-035 Two back-to-back requests -> second arvalid asserted 2 cycles after first burst's last beat.
REQ-036 rst_n low during beat 2 of len 7 -> outputs at reset values, rd_req_ready 1 after release, no further rd_data_valid.
REQ-037 With AXI_MST_RD_RESP_CHK_EN: rresp 2'b10 on beat 1, early rlast on beat 2 of len 3 -> rd_data_err on beats 1 and 2 only; without macro rd_data_err stays 0.
